// File: rtl/mem_pkg.sv
// mem_pkg: memory request/response channel payload types
// shared by the fetch, load/store and RAM-side blocks.
package mem_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

endpackage

// File: rtl/mem_req_arb2.sv
// mem_req_arb2: two-master round-robin arbiter in front of the RAM,
// with an order FIFO that steers in-order responses back.
module mem_req_arb2
    import mem_pkg::*;
#(
    parameter int OT_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      m0_req_valid,
    input  mem_req_t  m0_req,
    output logic      m0_req_ready,
    output logic      m0_resp_valid,
    output mem_resp_t m0_resp,
    input  logic      m0_resp_ready,
    input  logic      m1_req_valid,
    input  mem_req_t  m1_req,
    output logic      m1_req_ready,
    output logic      m1_resp_valid,
    output mem_resp_t m1_resp,
    input  logic      m1_resp_ready,
    output logic      s_req_valid,
    output mem_req_t  s_req,
    input  logic      s_req_ready,
    input  logic      s_resp_valid,
    input  mem_resp_t s_resp,
    output logic      s_resp_ready
);

    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;

    logic [OT_DEPTH-1:0] order_q;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                last_grant;
    logic                grant;
    logic                order_full;
    logic                order_empty;
    logic                ot_ok;
    logic                head;
    logic                push;
    logic                pop;

    assign order_full  = (count == CW'(OT_DEPTH));
    assign order_empty = (count == '0);
    assign ot_ok       = ~order_full;
    assign head        = order_q[rd_ptr];

    always_comb begin
        grant = 1'b0;
        priority case (1'b1)
            m0_req_valid & m1_req_valid: grant = ~last_grant;
            m1_req_valid:                grant = 1'b1;
            default:                     grant = 1'b0;
        endcase
    end

    // Outputs are forced low while reset is held, even combinational ones.
    assign s_req_valid  = rstn & ot_ok & (m0_req_valid | m1_req_valid);
    assign s_req        = grant ? m1_req : m0_req;
    assign m0_req_ready = rstn & ot_ok & s_req_ready & ~grant;
    assign m1_req_ready = rstn & ot_ok & s_req_ready & grant;

    assign m0_resp_valid = rstn & s_resp_valid & ~order_empty & ~head;
    assign m1_resp_valid = rstn & s_resp_valid & ~order_empty & head;
    assign m0_resp       = s_resp;
    assign m1_resp       = s_resp;
    assign s_resp_ready  = rstn & ~order_empty
                         & (head ? m1_resp_ready : m0_resp_ready);

    assign push = s_req_valid & s_req_ready;
    assign pop  = s_resp_valid & s_resp_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
            order_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (push) begin
                last_grant      <= grant;
                order_q[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A slave response with nothing outstanding means a broken slave.
    a_resp_without_req: assert property (
        @(posedge clk) disable iff (!rstn)
        !(s_resp_valid && order_empty)
    );

endmodule

// File: tb/tb_mem_req_arb2.sv
// tb_mem_req_arb2: directed vectors for the two-master memory
// request arbiter and its response routing.
module tb_mem_req_arb2;
    import mem_pkg::*;

    logic      clk = 1'b0;
    logic      rstn;
    logic      m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic      m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
    mem_req_t  m0_req, m1_req, s_req;
    mem_resp_t m0_resp, m1_resp, s_resp;
    logic      s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;

    int total = 0;
    int bad   = 0;

    mem_req_arb2 #(.OT_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req_valid(m0_req_valid), .m0_req(m0_req),
        .m0_req_ready(m0_req_ready), .m0_resp_valid(m0_resp_valid),
        .m0_resp(m0_resp), .m0_resp_ready(m0_resp_ready),
        .m1_req_valid(m1_req_valid), .m1_req(m1_req),
        .m1_req_ready(m1_req_ready), .m1_resp_valid(m1_resp_valid),
        .m1_resp(m1_resp), .m1_resp_ready(m1_resp_ready),
        .s_req_valid(s_req_valid), .s_req(s_req),
        .s_req_ready(s_req_ready), .s_resp_valid(s_resp_valid),
        .s_resp(s_resp), .s_resp_ready(s_resp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_req_valid  = 1'b0;
        m1_req_valid  = 1'b0;
        m0_req        = '0;
        m1_req        = '0;
        m0_resp_ready = 1'b0;
        m1_resp_ready = 1'b0;
        s_req_ready   = 1'b0;
        s_resp_valid  = 1'b0;
        s_resp        = '0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        m0_req_valid  = 1'b1;
        m1_req_valid  = 1'b1;
        s_req_ready   = 1'b1;
        m0_resp_ready = 1'b1;
        m1_resp_ready = 1'b1;
        #2;
        check("rst_sv", s_req_valid, 1'b0);
        check("rst_r0", m0_req_ready, 1'b0);
        check("rst_r1", m1_req_ready, 1'b0);
        check("rst_srr", s_resp_ready, 1'b0);
        check("rst_rv", {m0_resp_valid, m1_resp_valid}, 2'b00);

        // single master, back-to-back reads with 1-cycle responses
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m0_req_valid  = (i < 3);
            m0_req.addr   = 32'h100 + 32'(i * 4);
            s_req_ready   = 1'b1;
            s_resp_valid  = (i >= 1 && i <= 3);
            s_resp.rdata  = 32'hD0 + 32'(i);
            m0_resp_ready = 1'b1;
            #2;
            if (i < 3) begin
                check("t1_gnt", m0_req_ready, 1'b1);
                check("t1_addr", s_req.addr, 32'h100 + 32'(i * 4));
            end else begin
                check("t1_idle", s_req_valid, 1'b0);
            end
            check("t1_m1rv", m1_resp_valid, 1'b0);
            if (i >= 1 && i <= 3) begin
                check("t1_m0rv", m0_resp_valid, 1'b1);
                check("t1_data", m0_resp.rdata, 32'hD0 + 32'(i));
            end
        end

        // contention: alternate grants, responses follow grant order
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            m0_req_valid  = (i < 6);
            m1_req_valid  = (i < 6);
            m0_req.addr   = 32'h1000;
            m1_req.addr   = 32'h2000;
            s_req_ready   = 1'b1;
            s_resp_valid  = (i >= 1);
            s_resp.rdata  = 32'h300 + 32'(i);
            m0_resp_ready = 1'b1;
            m1_resp_ready = 1'b1;
            #2;
            if (i < 6) begin
                check("t2_g0", m0_req_ready, (i % 2) == 0);
                check("t2_g1", m1_req_ready, (i % 2) == 1);
                check("t2_addr", s_req.addr,
                      (i % 2) == 1 ? 32'h2000 : 32'h1000);
            end
            if (i >= 1) begin
                check("t2_rv0", m0_resp_valid, ((i - 1) % 2) == 0);
                check("t2_rv1", m1_resp_valid, ((i - 1) % 2) == 1);
            end
        end

        // outstanding limit; a pop does not free a slot the same cycle
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            m0_req_valid  = 1'b1;
            m0_req.addr   = 32'h3000;
            s_req_ready   = 1'b1;
            m0_resp_ready = 1'b1;
            s_resp_valid  = (i == 6);
            #2;
            check("t3_sv", s_req_valid, (i < 4) || (i == 7));
            check("t3_rdy", m0_req_ready, (i < 4) || (i == 7));
            if (i == 6) check("t3_pop", s_resp_ready, 1'b1);
        end

        // response backpressure on master 1
        do_reset();
        @(negedge clk);
        m1_req_valid = 1'b1;
        m1_req.addr  = 32'h4000;
        s_req_ready  = 1'b1;
        #2;
        check("t4_push", m1_req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m1_req_valid  = 1'b0;
            s_resp_valid  = 1'b1;
            s_resp.rdata  = 32'hBEEF;
            m0_resp_ready = 1'b1;
            m1_resp_ready = (i == 3);
            #2;
            check("t4_m1rv", m1_resp_valid, 1'b1);
            check("t4_m0rv", m0_resp_valid, 1'b0);
            check("t4_srr", s_resp_ready, i == 3);
        end
        check("t4_data", m1_resp.rdata, 32'hBEEF);
        @(negedge clk);
        s_resp_valid = 1'b0;
        m0_req_valid = 1'b1;
        #2;
        check("t4_m0push", m0_req_ready, 1'b1);
        @(negedge clk);
        m0_req_valid = 1'b0;
        s_resp_valid = 1'b1;
        s_resp.rdata = 32'h5555;
        #2;
        check("t4_head0", {m0_resp_valid, m1_resp_valid}, 2'b10);

        // simultaneous push and pop at count 2
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            m0_req_valid  = (i < 2) || (i == 3) || (i == 4) || (i == 5);
            m1_req_valid  = (i == 2);
            s_req_ready   = 1'b1;
            s_resp_valid  = (i == 2) || (i >= 6);
            m0_resp_ready = 1'b1;
            m1_resp_ready = 1'b1;
            #2;
            if (i < 2 || i == 3 || i == 4) check("t5_g0", m0_req_ready, 1'b1);
            if (i == 2) begin
                check("t5_g1", m1_req_ready, 1'b1);
                check("t5_pop", m0_resp_valid, 1'b1);
                check("t5_srr", s_resp_ready, 1'b1);
            end
            if (i == 5) check("t5_full", s_req_valid, 1'b0);
            if (i >= 6)
                check("t5_route", {m0_resp_valid, m1_resp_valid},
                      i == 7 ? 2'b01 : 2'b10);
        end

        // asynchronous reset with 3 outstanding requests
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m0_req_valid = 1'b1;
            m0_req.addr  = 32'h6000;
            s_req_ready  = 1'b1;
            #2;
            check("t6_push", m0_req_ready, 1'b1);
        end
        @(negedge clk);
        m1_req_valid  = 1'b1;
        m1_req.addr   = 32'h7000;
        s_resp_valid  = 1'b1;
        m0_resp_ready = 1'b1;
        m1_resp_ready = 1'b1;
        #2;
        check("t6_pre_sv", s_req_valid, 1'b1);
        check("t6_pre_rv", m0_resp_valid, 1'b1);
        #1 rstn = 1'b0;
        #1;
        check("t6_sv", s_req_valid, 1'b0);
        check("t6_rdy", {m0_req_ready, m1_req_ready}, 2'b00);
        check("t6_rv", {m0_resp_valid, m1_resp_valid}, 2'b00);
        check("t6_srr", s_resp_ready, 1'b0);
        s_resp_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #2;
        check("t6_first", {m0_req_ready, m1_req_ready}, 2'b10);
        check("t6_addr", s_req.addr, 32'h6000);
        check("t6_empty", s_resp_ready, 1'b0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
